top_sorter: RTL and testbench

- Serial bubble sorter for four signed two's-complement samples. One shared compare-swap unit is stepped by a small FSM.
- It repeatedly samples i1..i4, sorts them in ascending signed order over a fixed number of cycles, then publishes the result on o1..o4.
- It is a free-running datapath block with no start handshake. Downstream logic may use the done strobe to qualify fresh results.

---
 rtl/top_sorter.sv | 209 ++++++++++++++++++++
 tb/tb_top_sorter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/top_sorter.sv
// -----------------------------------------------------------------------------
// top_sorter
//
// Serial bubble sorter for four samples. One shared compare-swap unit is
// stepped by a small FSM through the six compares of a 4-element bubble sort.
// The block is free running with a fixed 8-clock frame:
//   LOAD -> S0 -> S1 -> S2 -> S3 -> S4 -> S5 -> PUB -> LOAD ...
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous, active-high reset; clears all state
//   i1..i4     unsorted samples, captured only on the LOAD edge
//   o1..o4     sorted result, o1 smallest .. o4 largest (registered)
//   done       one-cycle strobe, high in the cycle after o1..o4 update
//   dbg_state  current FSM state, for observation only
//
// Parameters:
//   WIDTH   bit width of each sample
//   SIGNED  1 = two's-complement compare, 0 = unsigned compare
//
// Handshake: there is no valid/ready pair. The block never stalls; done is
// the only qualifier and marks the single cycle in which a freshly published
// result first appears on o1..o4. Consumers that miss it still see the same
// values held until the next publish.
// -----------------------------------------------------------------------------
`default_nettype none

module top_sorter #(
   parameter int WIDTH  = 4,
   parameter int SIGNED = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [WIDTH-1:0] i4,
   output logic [WIDTH-1:0] o1,
   output logic [WIDTH-1:0] o2,
   output logic [WIDTH-1:0] o3,
   output logic [WIDTH-1:0] o4,
   output logic             done,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      LOAD = 3'd0,
      S0   = 3'd1,
      S1   = 3'd2,
      S2   = 3'd3,
      S3   = 3'd4,
      S4   = 3'd5,
      S5   = 3'd6,
      PUB  = 3'd7
   } state_t;

   state_t state;
   state_t state_nxt;

   // Working registers, r0 ends up smallest.
   logic [WIDTH-1:0] r0, r1, r2, r3;

   // Operands of the shared compare-swap unit.
   logic [WIDTH-1:0] cmp_left;
   logic [WIDTH-1:0] cmp_right;
   logic             swap;

   // Strict greater-than under the selected signedness. Equal operands give
   // 0, so equal values never move and the sort is stable.
   function automatic logic greater(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
      logic res;
      if (SIGNED != 0) begin
         res = ($signed(a) > $signed(b));
      end else begin
         res = (a > b);
      end
      return res;
   endfunction

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state: unconditional walk through the frame.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = LOAD;
      case (state)
         LOAD:    state_nxt = S0;
         S0:      state_nxt = S1;
         S1:      state_nxt = S2;
         S2:      state_nxt = S3;
         S3:      state_nxt = S4;
         S4:      state_nxt = S5;
         S5:      state_nxt = PUB;
         PUB:     state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // Compare-swap operand select. Pass 1 covers (0,1),(1,2),(2,3); pass 2
   // covers (0,1),(1,2); pass 3 covers (0,1). After pass k the top k slots
   // already hold their final values, so later passes stop short.
   // ---------------------------------------------------------------------------
   always_comb begin
      cmp_left  = '0;
      cmp_right = '0;
      case (state)
         S0, S3, S5: begin
            cmp_left  = r0;
            cmp_right = r1;
         end
         S1, S4: begin
            cmp_left  = r1;
            cmp_right = r2;
         end
         S2: begin
            cmp_left  = r2;
            cmp_right = r3;
         end
         default: begin
            cmp_left  = '0;
            cmp_right = '0;
         end
      endcase
   end

   assign swap = greater(cmp_left, cmp_right);

   // ---------------------------------------------------------------------------
   // Working registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0 <= '0;
         r1 <= '0;
         r2 <= '0;
         r3 <= '0;
      end else begin
         case (state)
            LOAD: begin
               r0 <= i1;
               r1 <= i2;
               r2 <= i3;
               r3 <= i4;
            end
            S0, S3, S5: begin
               if (swap) begin
                  r0 <= r1;
                  r1 <= r0;
               end
            end
            S1, S4: begin
               if (swap) begin
                  r1 <= r2;
                  r2 <= r1;
               end
            end
            S2: begin
               if (swap) begin
                  r2 <= r3;
                  r3 <= r2;
               end
            end
            default: begin
               // PUB leaves the working set untouched.
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output registers: updated only on the PUB edge, held otherwise. done is
   // cleared every other edge so it is a single-cycle strobe.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o1   <= '0;
         o2   <= '0;
         o3   <= '0;
         o4   <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == PUB) begin
            o1   <= r0;
            o2   <= r1;
            o3   <= r2;
            o4   <= r3;
            done <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_top_sorter.sv
// -----------------------------------------------------------------------------
// tb_top_sorter
//
// Drives a signed and an unsigned instance of top_sorter with the same inputs,
// frame by frame, and compares each published result against a reference
// sort computed in the bench.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_top_sorter;

   localparam int W = 4;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [W-1:0] i1, i2, i3, i4;
   logic [W-1:0] s_o1, s_o2, s_o3, s_o4;
   logic [W-1:0] u_o1, u_o2, u_o3, u_o4;
   logic         s_done, u_done;
   logic [2:0]   s_dbg, u_dbg;

   top_sorter #(.WIDTH(W), .SIGNED(1)) dut_s (
      .clk(clk), .rst(rst),
      .i1(i1), .i2(i2), .i3(i3), .i4(i4),
      .o1(s_o1), .o2(s_o2), .o3(s_o3), .o4(s_o4),
      .done(s_done), .dbg_state(s_dbg)
   );

   top_sorter #(.WIDTH(W), .SIGNED(0)) dut_u (
      .clk(clk), .rst(rst),
      .i1(i1), .i2(i2), .i3(i3), .i4(i4),
      .o1(u_o1), .o2(u_o2), .o3(u_o3), .o4(u_o4),
      .done(u_done), .dbg_state(u_dbg)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [4*W-1:0] exp_q[$];   // signed-instance expectations
   logic [4*W-1:0] exp_uq[$];  // unsigned-instance expectations
   logic [4*W-1:0] prev_s, prev_u;
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [4*W-1:0] obs,
                        input logic [4*W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: numeric key of a sample, then a stable insertion sort.
   function automatic int key(input logic [W-1:0] v, input bit sgn);
      int k;
      k = int'(v);
      if (sgn && v[W-1]) k = k - (1 << W);
      return k;
   endfunction

   function automatic logic [4*W-1:0] ref_sort(input logic [W-1:0] a,
      input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d,
      input bit sgn);
      logic [W-1:0] v[4];
      logic [W-1:0] t;
      int j;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 1; i < 4; i++) begin
         t = v[i];
         j = i - 1;
         while (j >= 0 && key(v[j], sgn) > key(t, sgn)) begin
            v[j+1] = v[j];
            j--;
         end
         v[j+1] = t;
      end
      return {v[0], v[1], v[2], v[3]};
   endfunction

   // ---------------------------------------------------------------------------
   // Driver: one full frame. Inputs are set just before the LOAD edge; the
   // optional mid set is applied while the FSM sits in S2.
   // ---------------------------------------------------------------------------
   task automatic run_frame(input string tag,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [W-1:0] c, input logic [W-1:0] d,
      input bit mid, input logic [4*W-1:0] mid_set);
      logic [4*W-1:0] es, eu;
      i1 = a; i2 = b; i3 = c; i4 = d;
      exp_q.push_back(ref_sort(a, b, c, d, 1'b1));
      exp_uq.push_back(ref_sort(a, b, c, d, 1'b0));
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (mid && n == 3) begin
            {i1, i2, i3, i4} = mid_set;
         end
         if (n == 1 || n == 7) begin
            check({tag, "/done_low_s"}, {15'd0, s_done}, 16'd0);
            check({tag, "/done_low_u"}, {15'd0, u_done}, 16'd0);
         end
         if (n == 4) begin
            check({tag, "/hold_s"}, {s_o1, s_o2, s_o3, s_o4}, prev_s);
            check({tag, "/hold_u"}, {u_o1, u_o2, u_o3, u_o4}, prev_u);
         end
      end
      es = exp_q.pop_front();
      eu = exp_uq.pop_front();
      check({tag, "/done_s"}, {15'd0, s_done}, 16'd1);
      check({tag, "/done_u"}, {15'd0, u_done}, 16'd1);
      check({tag, "/sorted_s"}, {s_o1, s_o2, s_o3, s_o4}, es);
      check({tag, "/sorted_u"}, {u_o1, u_o2, u_o3, u_o4}, eu);
      prev_s = es;
      prev_u = eu;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence followed by random frames
   // ---------------------------------------------------------------------------
   initial begin
      i1 = '0; i2 = '0; i3 = '0; i4 = '0;
      prev_s = '0;
      prev_u = '0;
      #12;
      check("reset_out_s", {s_o1, s_o2, s_o3, s_o4}, 16'h0000);
      check("reset_out_u", {u_o1, u_o2, u_o3, u_o4}, 16'h0000);
      check("reset_done", {14'd0, s_done, u_done}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // Mixed signs, twice to see done repeat every 8 cycles.
      run_frame("mixed1", 4'h6, 4'hE, 4'hC, 4'h1, 1'b0, '0);
      check("mixed_lit", {s_o1, s_o2, s_o3, s_o4}, 16'hCE16);
      check("unsigned_lit", {u_o1, u_o2, u_o3, u_o4}, 16'h16CE);
      run_frame("mixed2", 4'h6, 4'hE, 4'hC, 4'h1, 1'b0, '0);
      // Reverse order with both extremes.
      run_frame("reverse", 4'h7, 4'h3, 4'h0, 4'h8, 1'b0, '0);
      check("reverse_lit", {s_o1, s_o2, s_o3, s_o4}, 16'h8037);
      // Duplicates and already sorted.
      run_frame("dups", 4'hF, 4'hF, 4'h2, 4'h2, 1'b0, '0);
      check("dups_lit", {s_o1, s_o2, s_o3, s_o4}, 16'hFF22);
      run_frame("sorted", 4'h1, 4'h2, 4'h3, 4'h4, 1'b0, '0);
      // Inputs change in S2: this frame keeps the old set, next takes the new.
      run_frame("midchg_old", 4'h5, 4'h4, 4'h9, 4'h0, 1'b1, 16'h3A71);
      run_frame("midchg_new", 4'h3, 4'hA, 4'h7, 4'h1, 1'b0, '0);

      // Asynchronous reset in the middle of a frame.
      i1 = 4'h2; i2 = 4'hB; i3 = 4'h6; i4 = 4'h9;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_s", {s_o1, s_o2, s_o3, s_o4}, 16'h0000);
      check("async_rst_out_u", {u_o1, u_o2, u_o3, u_o4}, 16'h0000);
      check("async_rst_done", {14'd0, s_done, u_done}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_s = '0;
      prev_u = '0;
      run_frame("after_rst", 4'h2, 4'hB, 4'h6, 4'h9, 1'b0, '0);

      // Random frames.
      for (int f = 0; f < 24; f++) begin
         run_frame("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'b0, '0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Safety bound on total run time.
   initial begin
      #100000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
